mul_seq_8bit: RTL and testbench

MUL_SEQ_8BIT -- requirements
Module: mul_seq_8bit

---
 rtl/mul_seq_8bit.sv | 78 +++++++
 tb/tb_mul_seq_8bit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mul_seq_8bit.sv
// Unsigned 8x8 sequential shift-and-add multiplier.
// One 8-bit adder with carry-out is reused for eight iterations.
module mul_seq_8bit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  output logic        busy,
  output logic        done,
  output logic [15:0] PRODUCT
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [7:0]  m;
  logic [16:0] p;
  logic [3:0]  cnt;
  logic [7:0]  addend;
  logic [8:0]  sum;
  logic [16:0] p_next;

  // Carry-out lands in p_next[15] so the top bit is never lost.
  always_comb begin
    addend = p[0] ? m : 8'h00;
    sum    = {1'b0, p[15:8]} + {1'b0, addend};
    p_next = {1'b0, sum, p[7:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      PRODUCT <= 16'h0000;
      m       <= 8'h00;
      p       <= 17'h0;
      cnt     <= 4'h0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            m     <= A;
            p     <= {9'b0, B};
            cnt   <= 4'h0;
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          p   <= p_next;
          cnt <= cnt + 4'h1;
          if (cnt == 4'd7) begin
            PRODUCT <= p_next[15:0];
            state   <= DONE;
            done    <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq_8bit.sv
// Directed and random checks for the sequential multiplier.
// Latency, pulse count, reset abort and product values.
module tb_mul_seq_8bit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  A;
  logic [7:0]  B;
  logic        busy;
  logic        done;
  logic [15:0] PRODUCT;

  int nvec;
  int nerr;

  int          first;
  int          pulses;
  logic        bs1, bs8, bs9, bs10;
  logic [15:0] prod8;

  mul_seq_8bit dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .A      (A),
    .B      (B),
    .busy   (busy),
    .done   (done),
    .PRODUCT(PRODUCT)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Start at edge E, observe 11 further edges.
  task automatic op(input logic [7:0] a, input logic [7:0] b,
                    input bit hold);
    start = 1'b1;
    A = a;
    B = b;
    tick();
    bs1 = busy;
    if (!hold) start = 1'b0;
    first  = 0;
    pulses = 0;
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (done) begin
        pulses++;
        if (first == 0) first = k;
      end
      if (hold && k == 3) begin
        A = ~a;
        B = b + 8'd1;
      end
      if (k == 8) begin
        bs8   = busy;
        prod8 = PRODUCT;
      end
      if (k == 9) bs9 = busy;
      if (k == 10) bs10 = busy;
    end
    start = 1'b0;
  endtask

  task automatic simple(input string tag, input logic [7:0] a,
                        input logic [7:0] b, input logic [15:0] exp);
    op(a, b, 1'b0);
    chk({tag, "_done_at"}, first, 8);
    chk({tag, "_pulses"}, pulses, 1);
    chk({tag, "_prod"}, prod8, exp);
    chk({tag, "_hold"}, PRODUCT, exp);
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic [7:0] cv [4];
    nvec  = 0;
    nerr  = 0;
    rst   = 1'b1;
    start = 1'b0;
    A     = 8'h00;
    B     = 8'h00;
    cv[0] = 8'h00;
    cv[1] = 8'h01;
    cv[2] = 8'h80;
    cv[3] = 8'hFF;

    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_prod", PRODUCT, 0);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_busy", busy, 0);
      chk("idle_prod", PRODUCT, 0);
    end

    // 0x0D * 0x0B = 143
    op(8'h0D, 8'h0B, 1'b0);
    chk("d13_busy_e1", bs1, 1);
    chk("d13_busy_e8", bs8, 1);
    chk("d13_busy_e9", bs9, 0);
    chk("d13_done_at", first, 8);
    chk("d13_pulses", pulses, 1);
    chk("d13_prod", prod8, 16'h008F);

    simple("ffff", 8'hFF, 8'hFF, 16'hFE01);
    simple("zero", 8'h00, 8'hFF, 16'h0000);

    // held start: 0x12*0x34 then 0xED*0x35 accepted at E+10
    op(8'h12, 8'h34, 1'b1);
    chk("hold_done_at", first, 8);
    chk("hold_pulses", pulses, 1);
    chk("hold_prod", prod8, 16'h03A8);
    chk("hold_busy_e9", bs9, 0);
    chk("hold_busy_e10", bs10, 1);
    for (int k = 0; k < 12; k++) tick();
    chk("hold2_prod", PRODUCT, 16'h3111);
    chk("hold2_busy", busy, 0);

    // reset at E+4 aborts
    start = 1'b1;
    A = 8'h55;
    B = 8'h77;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 3; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_prod", PRODUCT, 0);
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (done) pulses++;
    end
    chk("abort_no_done", pulses, 0);
    chk("abort_prod2", PRODUCT, 0);
    simple("post_rst", 8'h80, 8'h02, 16'h0100);

    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        logic [15:0] e;
        e = 16'({8'h00, cv[i]} * {8'h00, cv[j]});
        simple("corner", cv[i], cv[j], e);
      end

    for (int n = 0; n < 1000; n++) begin
      logic [15:0] e;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      e  = 16'({8'h00, ra} * {8'h00, rb});
      op(ra, rb, 1'b0);
      chk("rand_prod", prod8, e);
      chk("rand_done_at", first, 8);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
